// File: rtl/mux_rr_reg_pkg.sv
// Shared defaults and the round-robin pointer helper for the registered mux.
package mux_pkg;

  localparam int unsigned DefaultWidth = 16;
  localparam int unsigned DefaultNumIn = 3;

  // Pointer advance with wrap: the channel after the winner, or 0 past the last one.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr >= n - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/mux_rr_reg_if.sv
// Handshake bundle between N producers, the registered mux and one consumer.
interface mux_rr_reg_if
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned NUM_IN = DefaultNumIn
) ();

  localparam int unsigned SRC_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [WIDTH-1:0]  in_data [NUM_IN];
  logic [NUM_IN-1:0] in_valid;
  logic [NUM_IN-1:0] in_ready;
  logic [WIDTH-1:0]  out_data;
  logic [SRC_W-1:0]  out_src;
  logic              out_valid;
  logic              out_ready;

  // Environment side: producers plus the downstream consumer.
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_src,
    input  out_valid,
    output out_ready
  );

  // Mux side.
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_src,
    output out_valid,
    input  out_ready
  );

endinterface

// File: rtl/mux_rr_reg_arbiter.sv
// Combinational round-robin arbiter; the priority pointer is owned by the parent.
module rr_arbiter #(
  parameter  int unsigned NUM_IN = 3,
  localparam int unsigned SRC_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [SRC_W-1:0]  ptr_i,
  input  logic              en_i,
  output logic [NUM_IN-1:0] gnt_o,
  output logic [SRC_W-1:0]  gnt_idx_o,
  output logic              gnt_any_o
);

  int unsigned idx;
  logic        found;

  // Scan ptr, ptr+1, ... with wrap; first requester wins. gnt_o is gated by en_i only.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 32'd0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      idx = 32'(ptr_i) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!found && req_i[idx]) begin
        found     = 1'b1;
        gnt_idx_o = SRC_W'(idx);
      end
    end
    if (en_i && found) gnt_o[gnt_idx_o] = 1'b1;
  end

  assign gnt_any_o = |req_i;

endmodule

// File: rtl/mux_rr_reg.sv
// Registered N-to-1 mux with round-robin arbitration, backpressure and source tagging.
module mux_rr_reg
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned NUM_IN = DefaultNumIn
) (
  input logic         clk,
  input logic         rst_n,
  mux_rr_reg_if.slave bus_io
);

  localparam int unsigned SRC_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SRC_W-1:0]  out_src_q, out_src_d;
  logic              out_valid_q, out_valid_d;
  logic [SRC_W-1:0]  ptr_q, ptr_d;

  logic              load;
  logic [NUM_IN-1:0] gnt;
  logic [SRC_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic [WIDTH-1:0]  mux_data;

  // The output register can take a word when empty or being drained this cycle.
  assign load = !out_valid_q || bus_io.out_ready;

  rr_arbiter #(
    .NUM_IN (NUM_IN)
  ) u_arb (
    .req_i     (bus_io.in_valid),
    .ptr_i     (ptr_q),
    .en_i      (load),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  assign bus_io.in_ready = gnt;

  // AND-OR select of the granted channel's payload.
  always_comb begin
    mux_data = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      mux_data = mux_data | (bus_io.in_data[i] & {WIDTH{gnt[i]}});
    end
  end

  // Next state: capture on transfer, empty on idle load, hold under backpressure.
  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = gnt_any;
      if (gnt_any) begin
        out_data_d = mux_data;
        out_src_d  = gnt_idx;
        ptr_d      = SRC_W'(rr_next(32'(gnt_idx), NUM_IN));
      end
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus_io.out_data  = out_data_q;
  assign bus_io.out_src   = out_src_q;
  assign bus_io.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_reg.sv
// Self-checking bench for mux_rr_reg (WIDTH=16, NUM_IN=3) with a grant model and scoreboard.
module tb_mux_rr_reg;

  localparam int unsigned W = 16;
  localparam int unsigned N = 3;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mux_rr_reg_if #(.WIDTH(W), .NUM_IN(N)) bus ();

  mux_rr_reg #(
    .WIDTH  (W),
    .NUM_IN (N)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  src;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] din [3];
  bit          m_valid;
  logic [15:0] m_data;
  logic [1:0]  m_src;
  int          m_ptr;
  int          n_cmp;
  int          n_err;

  function automatic int model_grant(input logic [2:0] v, input int p);
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (p + k) % 3;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Drive one cycle starting at posedge+1; returns observed/expected in_ready and transfer flag.
  task automatic step(input logic [2:0] v, input logic ordy,
                      output logic [2:0] rdy_obs, output logic [2:0] rdy_exp, output bit xfer);
    int  g;
    bit  load;
    for (int i = 0; i < 3; i++) bus.in_data[i] = din[i];
    bus.in_valid  = v;
    bus.out_ready = ordy;
    #1;
    rdy_obs = bus.in_ready;
    load    = !m_valid || ordy;
    rdy_exp = 3'b000;
    xfer    = 1'b0;
    if (load && (v != 3'b000)) begin
      g = model_grant(v, m_ptr);
      rdy_exp[g] = 1'b1;
      xfer = 1'b1;
      exp_q.push_back('{data: din[g], src: 2'(g)});
      m_data = din[g];
      m_src  = 2'(g);
      m_ptr  = (g == 2) ? 0 : g + 1;
    end
    if (load) m_valid = (v != 3'b000);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] ro, re;
    bit         x;
    exp_t       e;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 || bus.out_src !== 2'd0) begin
      n_err++;
      $display("FAIL reset_init: got v=%b d=%h s=%0d want 0/0/0",
               bus.out_valid, bus.out_data, bus.out_src);
    end
    din[2] = 16'hCAFE;
    step(3'b100, 1'b1, ro, re, x);
    e = exp_q.pop_front();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_src !== e.src) begin
      n_err++;
      $display("FAIL reset_preload: got v=%b d=%h s=%0d want 1/%h/%0d",
               bus.out_valid, bus.out_data, bus.out_src, e.data, e.src);
    end
    // Reset mid-cycle while a word is held and a new one is offered.
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 || bus.out_src !== 2'd0) begin
      n_err++;
      $display("FAIL reset_async: got v=%b d=%h s=%0d want 0/0/0",
               bus.out_valid, bus.out_data, bus.out_src);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0) begin
      n_err++;
      $display("FAIL reset_hold: got v=%b d=%h want 0/0", bus.out_valid, bus.out_data);
    end
    bus.in_valid = 3'b000;
    m_valid = 1'b0; m_data = '0; m_src = '0; m_ptr = 0;
    exp_q.delete();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 3'b000) begin
      n_err++;
      $display("FAIL reset_release: got v=%b rdy=%b want 0/000", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_single();
    logic [2:0] ro, re;
    bit         x;
    exp_t       e;
    din[0] = 16'h0000; din[1] = 16'hBEEF; din[2] = 16'h0000;
    step(3'b010, 1'b1, ro, re, x);
    n_cmp++;
    if (ro !== 3'b010) begin
      n_err++;
      $display("FAIL single_rdy: got %b want 010", ro);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hBEEF || bus.out_src !== 2'd1 ||
        e.data !== bus.out_data) begin
      n_err++;
      $display("FAIL single_out: got v=%b d=%h s=%0d want 1/beef/1",
               bus.out_valid, bus.out_data, bus.out_src);
    end
  endtask

  task automatic test_wrap();
    logic [2:0] ro, re;
    bit         x;
    exp_t       e;
    din[0] = 16'h0A0A; din[1] = 16'h1B1B; din[2] = 16'h2C2C;
    // Pointer is 2 after the single-request test.
    step(3'b001, 1'b1, ro, re, x);
    e = exp_q.pop_front();
    n_cmp++;
    if (ro !== 3'b001 || bus.out_src !== 2'd0 || bus.out_data !== e.data) begin
      n_err++;
      $display("FAIL wrap_ch0: got rdy=%b s=%0d d=%h want 001/0/%h",
               ro, bus.out_src, bus.out_data, e.data);
    end
    step(3'b101, 1'b1, ro, re, x);
    e = exp_q.pop_front();
    n_cmp++;
    if (ro !== 3'b100 || bus.out_src !== 2'd2 || bus.out_data !== e.data) begin
      n_err++;
      $display("FAIL wrap_ch2: got rdy=%b s=%0d d=%h want 100/2/%h",
               ro, bus.out_src, bus.out_data, e.data);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] ro, re;
    bit         x;
    exp_t       e;
    din[0] = 16'h00A0; din[1] = 16'h00A1; din[2] = 16'h00A2;
    for (int k = 0; k < 6; k++) begin
      step(3'b111, 1'b1, ro, re, x);
      e = exp_q.pop_front();
      n_cmp++;
      if (ro !== re || bus.out_valid !== 1'b1 || bus.out_src !== 2'(k % 3) ||
          bus.out_data !== e.data) begin
        n_err++;
        $display("FAIL rr_%0d: got rdy=%b v=%b s=%0d d=%h want %b/1/%0d/%h",
                 k, ro, bus.out_valid, bus.out_src, bus.out_data, re, k % 3, e.data);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] ro, re;
    bit         x;
    exp_t       e;
    din[0] = 16'h1234;
    step(3'b001, 1'b1, ro, re, x);
    e = exp_q.pop_front();
    n_cmp++;
    if (bus.out_data !== 16'h1234 || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_load: got v=%b d=%h want 1/1234", bus.out_valid, bus.out_data);
    end
    din[0] = 16'h5550; din[1] = 16'h5551; din[2] = 16'h5552;
    for (int k = 0; k < 5; k++) begin
      step(3'b111, 1'b0, ro, re, x);
      n_cmp++;
      if (ro !== 3'b000 || bus.out_data !== 16'h1234 || bus.out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got rdy=%b v=%b d=%h want 000/1/1234",
                 k, ro, bus.out_valid, bus.out_data);
      end
    end
    step(3'b111, 1'b1, ro, re, x);
    e = exp_q.pop_front();
    n_cmp++;
    if (ro !== 3'b010 || bus.out_data !== 16'h5551 || bus.out_src !== 2'd1 ||
        e.data !== bus.out_data) begin
      n_err++;
      $display("FAIL bp_release: got rdy=%b d=%h s=%0d want 010/5551/1",
               ro, bus.out_data, bus.out_src);
    end
  endtask

  task automatic test_drain();
    logic [2:0] ro, re;
    bit         x;
    step(3'b000, 1'b1, ro, re, x);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== m_data || ro !== 3'b000) begin
      n_err++;
      $display("FAIL drain: got v=%b d=%h rdy=%b want 0/%h/000",
               bus.out_valid, bus.out_data, ro, m_data);
    end
  endtask

  task automatic test_random();
    logic [2:0] ro, re;
    bit         x;
    exp_t       e;
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 3; i++) din[i] = 16'($urandom);
      step(3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), ro, re, x);
      n_cmp++;
      if (ro !== re) begin
        n_err++;
        $display("FAIL rand_rdy_%0d: got %b want %b", k, ro, re);
      end
      if (x) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_src !== e.src) begin
          n_err++;
          $display("FAIL rand_word_%0d: got v=%b d=%h s=%0d want 1/%h/%0d",
                   k, bus.out_valid, bus.out_data, bus.out_src, e.data, e.src);
        end
      end else begin
        n_cmp++;
        if (bus.out_valid !== m_valid || bus.out_data !== m_data || bus.out_src !== m_src) begin
          n_err++;
          $display("FAIL rand_hold_%0d: got v=%b d=%h s=%0d want %b/%h/%0d",
                   k, bus.out_valid, bus.out_data, bus.out_src, m_valid, m_data, m_src);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_valid = 1'b0; m_data = '0; m_src = '0; m_ptr = 0;
    for (int i = 0; i < 3; i++) begin
      din[i] = '0;
      bus.in_data[i] = '0;
    end
    bus.in_valid  = 3'b000;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_rr_reg.md
Name: mux_rr_reg

Overview:
- Parametrised registered N-to-1 datapath mux with per-channel valid/ready handshakes.
- A round-robin arbiter chooses at most one requesting channel per cycle and captures its payload into a single output register.
- Sits between multiple ALU operand/result producers and one consumer.
- Successor to the fixed 3x16 one-hot registered mux: it adds generic width and channel count, fairness, backpressure, source tagging, and defined reset.

Parameters:
- WIDTH, 16, payload width in bits (>=1).
- NUM_IN, 3, number of input channels (>=1).
- SRC_W, (NUM_IN>1 ? $clog2(NUM_IN) : 1), width of the source index. Derived; not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  [WIDTH-1:0] x NUM_IN (unpacked)  per-channel payload.
- in_valid  input  NUM_IN  per-channel request.
- in_ready  output  NUM_IN  per-channel accept; combinational, at most one bit high.
- out_data  output  WIDTH  registered payload.
- out_src  output  SRC_W  index of the channel that supplied out_data.
- out_valid  output  1  output register holds valid data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset: rst_n low asynchronously forces the following regardless of clk:
  - out_valid=0, out_data=0, out_src=0.
  - Round-robin pointer ptr=0.
  - All registers hold these values while rst_n is low.
- Load condition: load = !out_valid || out_ready. The output register may accept new data only when load=1.
- Grant:
  - g = first index i with in_valid[i]=1, searching ptr, ptr+1, ..., NUM_IN-1, 0, ..., ptr-1.
  - gnt_any = |in_valid.
- in_ready[i] = load && gnt_any && (i == g). All other bits are 0. in_ready never depends on in_data.
- Transfer on a channel: in_valid[i] && in_ready[i] at a rising edge. On that edge:
  - out_data <= in_data[g], out_src <= g, out_valid <= 1.
  - ptr <= (g == NUM_IN-1) ? 0 : g+1.
- load && !gnt_any: out_valid <= 0. out_data, out_src and ptr hold.
- !load (out_valid && !out_ready): all registers hold. No input is accepted.
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 word/cycle when out_ready is held high.
- Fairness: a continuously requesting channel is granted within NUM_IN transfers.
- Simultaneous downstream accept and upstream transfer in the same cycle: the new word replaces the old one with no bubble.
- Inputs are unconstrained: in_valid may drop without a transfer, and it may be multi-hot.
- NUM_IN=1: ptr is constant 0, out_src is always 0, and the block behaves as a 1-deep pipeline register.
- Reset asserted mid-transfer discards the held word. The first cycle after release behaves as empty (load=1).
- No X propagation: out_data changes only on a transfer.

Decomposition:
- Package mux_pkg: localparams for the default WIDTH/NUM_IN, plus a function rr_next(ptr, n) implementing the wrap increment.
- Sub-module rr_arbiter #(NUM_IN):
  - Inputs: req, ptr, en (=load).
  - Outputs: one-hot gnt, gnt_idx, gnt_any.
  - Purely combinational; ptr stays in the parent.
- The parent holds the output register, ptr, and the data mux, which is an AND-OR of in_data gated by gnt.

Test Plan (WIDTH=16, NUM_IN=3):
- Reset: assert rst_n=0 mid-cycle with out_valid=1 -> out_valid, out_data, out_src all 0 immediately. After release with in_valid=0 -> out_valid stays 0.
- Single request: in_valid=3'b010, in_data[1]=16'hBEEF, out_ready=1 -> in_ready=3'b010. Next cycle out_data=16'hBEEF, out_src=1, out_valid=1; ptr becomes 2.
- Round-robin with all three requesting, out_ready=1, data A0/A1/A2, starting at ptr=0 -> grant order 0,1,2,0,... out_src sequence 0,1,2,0 on consecutive cycles with no bubbles.
- Backpressure: out_valid=1 holding 16'h1234, out_ready=0, in_valid=3'b111 -> in_ready=0. out_data stays 16'h1234 for 5 cycles. Raising out_ready -> transfer the same cycle; new data appears next cycle.
- Wrap: ptr=2, in_valid=3'b001 -> channel 0 granted, ptr becomes 1. Then in_valid=3'b101 -> channel 2 granted (search starts at 1), ptr becomes 0.
- Drain: after the last transfer, in_valid=0, out_ready=1 -> out_valid=0 on the next cycle and out_data unchanged.
